// File: rtl/knights_pkg.sv
// Shared constants and FSM state type for the knight's-tour command sequencer.
package knights_pkg;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;
  localparam logic [7:0] WEST  = 8'h3F;

  localparam logic [3:0] MOVE         = 4'h4;
  localparam logic [3:0] MOVE_FANFARE = 4'h5;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    HOLD_VERT,
    HORZ,
    HOLD_HORZ
  } state_t;

  // Command word layout: opcode | heading | squares
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/move_decode.sv
// Maps a one-hot knight move to its vertical and horizontal leg commands.
module move_decode
  import knights_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o,
  output logic        valid_o
);

  always_comb begin
    vert_cmd_o = '0;
    horz_cmd_o = '0;
    valid_o    = 1'b1;
    case (move_i)
      8'h01: begin vert_cmd_o = mk_cmd(MOVE, NORTH, 4'd2); horz_cmd_o = mk_cmd(MOVE_FANFARE, EAST, 4'd1); end
      8'h02: begin vert_cmd_o = mk_cmd(MOVE, NORTH, 4'd2); horz_cmd_o = mk_cmd(MOVE_FANFARE, WEST, 4'd1); end
      8'h04: begin vert_cmd_o = mk_cmd(MOVE, NORTH, 4'd1); horz_cmd_o = mk_cmd(MOVE_FANFARE, WEST, 4'd2); end
      8'h08: begin vert_cmd_o = mk_cmd(MOVE, SOUTH, 4'd1); horz_cmd_o = mk_cmd(MOVE_FANFARE, WEST, 4'd2); end
      8'h10: begin vert_cmd_o = mk_cmd(MOVE, SOUTH, 4'd2); horz_cmd_o = mk_cmd(MOVE_FANFARE, WEST, 4'd1); end
      8'h20: begin vert_cmd_o = mk_cmd(MOVE, SOUTH, 4'd2); horz_cmd_o = mk_cmd(MOVE_FANFARE, EAST, 4'd1); end
      8'h40: begin vert_cmd_o = mk_cmd(MOVE, SOUTH, 4'd1); horz_cmd_o = mk_cmd(MOVE_FANFARE, EAST, 4'd2); end
      8'h80: begin vert_cmd_o = mk_cmd(MOVE, NORTH, 4'd1); horz_cmd_o = mk_cmd(MOVE_FANFARE, EAST, 4'd2); end
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Sequences a solved knight's tour into vertical/horizontal commands for cmd_proc,
// passing UART commands straight through while idle.
//   state     | meaning
//   IDLE      | UART commands pass through to cmd_proc
//   VERT      | vertical leg offered (first cycle latches the move)
//   HOLD_VERT | vertical leg consumed, waiting for completion
//   HORZ      | horizontal leg offered
//   HOLD_HORZ | horizontal leg consumed, waiting for completion
module tour_cmd
  import knights_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic [7:0]  move_q, move_d;
  logic        ld_q, ld_d;
  logic [15:0] vert_cmd, horz_cmd;
  logic        move_valid;
  logic        tour_rdy;
  logic        last_move;
  logic        idle_view;

  move_decode u_dec (
    .move_i    (move_q),
    .vert_cmd_o(vert_cmd),
    .horz_cmd_o(horz_cmd),
    .valid_o   (move_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
      move_q    <= '0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      move_q    <= move_d;
      ld_q      <= ld_d;
    end
  end

  assign last_move = (mv_indx_q == LAST_IDX);
  // Memory read for the new index lands one cycle after entry, so VERT spends
  // its first cycle latching the move before offering a command.
  assign tour_rdy  = ((state_q == VERT) && !ld_q && move_valid) || (state_q == HORZ);

  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    move_d    = ld_q ? move : move_q;
    ld_d      = 1'b0;
    case (state_q)
      IDLE: if (start_tour) begin
        state_d   = VERT;
        mv_indx_d = '0;
        ld_d      = 1'b1;
      end
      VERT: begin
        if (!ld_q) begin
          if (!move_valid)      state_d = IDLE;
          else if (clr_cmd_rdy) state_d = HOLD_VERT;
        end
      end
      HOLD_VERT: if (send_resp) state_d = HORZ;
      HORZ:      if (clr_cmd_rdy) state_d = HOLD_HORZ;
      HOLD_HORZ: if (send_resp) begin
        if (last_move) begin
          state_d = IDLE;
        end else begin
          state_d   = VERT;
          mv_indx_d = mv_indx_q + 5'd1;
          ld_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset is synchronous, so the output mux treats rst_n low as idle immediately.
  assign idle_view = (state_q == IDLE) || !rst_n;

  always_comb begin
    cmd              = vert_cmd;
    cmd_rdy          = tour_rdy;
    clr_cmd_rdy_UART = 1'b0;
    resp             = 8'h5A;
    if (idle_view) begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
      resp             = 8'hA5;
    end else begin
      if ((state_q == HORZ) || (state_q == HOLD_HORZ)) cmd = horz_cmd;
      if ((state_q == HOLD_HORZ) && last_move)         resp = 8'hA5;
    end
  end

  assign mv_indx = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Randomized directed bench for tour_cmd against a dx/dy move-table reference.
module tb_tour_cmd;

  logic        clk;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;

  logic [7:0]  mem [0:31];
  int          checks = 0;
  int          errors = 0;

  tour_cmd #(.NUM_MOVES(24)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_tour      (start_tour),
    .move            (move),
    .mv_indx         (mv_indx),
    .cmd_UART        (cmd_UART),
    .cmd_rdy_UART    (cmd_rdy_UART),
    .clr_cmd_rdy     (clr_cmd_rdy),
    .send_resp       (send_resp),
    .cmd             (cmd),
    .cmd_rdy         (cmd_rdy),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .resp            (resp)
  );

  // Solver memory model: combinational read at the current index
  assign move = mem[mv_indx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: knight move as (dx,dy), commands built from signs and magnitudes
  task automatic ref_cmds(input logic [7:0] mv, output logic [15:0] ev, output logic [15:0] eh);
    int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int b = 0;
    int ax, ay;
    for (int i = 0; i < 8; i++) if (mv[i]) b = i;
    ax = (dxs[b] < 0) ? -dxs[b] : dxs[b];
    ay = (dys[b] < 0) ? -dys[b] : dys[b];
    ev = {4'h4, (dys[b] > 0) ? 8'h00 : 8'h7F, 4'(ay)};
    eh = {4'h5, (dxs[b] > 0) ? 8'hBF : 8'h3F, 4'(ax)};
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 8 && cmd_rdy !== 1'b1; i++) step();
    check(tag, cmd_rdy, 1'b1);
  endtask

  task automatic do_move(input int k, input bit last, input bit stop_in_hold);
    logic [15:0] ev, eh;
    ref_cmds(mem[k], ev, eh);
    cmd_UART     = 16'($urandom);
    cmd_rdy_UART = 1'b1;
    wait_rdy("vert_rdy");
    check("vert_cmd", cmd, ev);
    check("vert_idx", mv_indx, k);
    check("vert_resp", resp, 8'h5A);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    check("vert_stray_resp", {cmd_rdy, cmd}, {1'b1, ev});
    clr_cmd_rdy = 1'b1;
    #1;
    check("tour_clr_fwd", clr_cmd_rdy_UART, 1'b0);
    step();
    clr_cmd_rdy = 1'b0;
    check("hold_vert_rdy", cmd_rdy, 1'b0);
    repeat ($urandom_range(2, 0)) step();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
    check("start_ignored_idx", mv_indx, k);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    wait_rdy("horz_rdy");
    check("horz_cmd", cmd, eh);
    check("horz_resp", resp, 8'h5A);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    check("hold_horz_rdy", cmd_rdy, 1'b0);
    check("hold_horz_resp", resp, last ? 8'hA5 : 8'h5A);
    check("hold_horz_idx", mv_indx, k);
    if (!stop_in_hold) begin
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
      check("next_idx", mv_indx, last ? k : k + 1);
    end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  task automatic abort_case(input logic [7:0] bad, input string tag);
    mem[0]       = bad;
    cmd_rdy_UART = 1'b0;
    pulse_start();
    check({tag, "_busy"}, resp, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_no_rdy"}, cmd_rdy, 1'b0);
      step();
    end
    check({tag, "_idle_resp"}, resp, 8'hA5);
    check({tag, "_idx"}, mv_indx, 5'd0);
    cmd_rdy_UART = 1'b1;
    #1;
    check({tag, "_idle_pass"}, cmd_rdy, 1'b1);
  endtask

  initial begin
    logic [15:0] u;
    rst_n        = 1'b0;
    start_tour   = 1'b0;
    clr_cmd_rdy  = 1'b0;
    send_resp    = 1'b0;
    cmd_UART     = 16'($urandom);
    cmd_rdy_UART = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
    step();
    step();
    check("rst_idx", mv_indx, 5'd0);
    check("rst_resp", resp, 8'hA5);
    check("rst_cmd", cmd, cmd_UART);
    check("rst_rdy", cmd_rdy, 1'b1);
    rst_n = 1'b1;
    step();

    cmd_UART     = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    check("idle_cmd", cmd, 16'h2000);
    check("idle_rdy", cmd_rdy, 1'b1);
    check("idle_resp", resp, 8'hA5);
    clr_cmd_rdy = 1'b1;
    #1;
    check("idle_clr_fwd", clr_cmd_rdy_UART, 1'b1);
    step();
    clr_cmd_rdy = 1'b0;
    #1;
    check("idle_clr_drop", clr_cmd_rdy_UART, 1'b0);
    for (int i = 0; i < 4; i++) begin
      u            = 16'($urandom);
      cmd_UART     = u;
      cmd_rdy_UART = 1'($urandom);
      #1;
      check("idle_pass_cmd", cmd, u);
      check("idle_pass_rdy", cmd_rdy, cmd_rdy_UART);
      step();
    end

    // Full tour, with known moves at the front
    mem[0] = 8'h01;
    mem[1] = 8'h08;
    pulse_start();
    for (int k = 0; k < 24; k++) do_move(k, k == 23, 1'b0);
    check("end_resp", resp, 8'hA5);
    cmd_UART     = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    check("end_pass_cmd", cmd, 16'h1234);
    check("end_pass_rdy", cmd_rdy, 1'b1);
    send_resp   = 1'b1;
    clr_cmd_rdy = 1'b1;
    step();
    step();
    send_resp   = 1'b0;
    clr_cmd_rdy = 1'b0;
    check("end_idx_hold", mv_indx, 5'd23);

    abort_case(8'h00, "abort_zero");
    abort_case(8'h03, "abort_multi");

    // Mid-tour reset during the sixth move's completion wait
    for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
    pulse_start();
    for (int k = 0; k < 5; k++) do_move(k, 1'b0, 1'b0);
    do_move(5, 1'b0, 1'b1);
    cmd_UART     = 16'hBEEF;
    cmd_rdy_UART = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("mid_rst_resp", resp, 8'hA5);
    check("mid_rst_cmd", cmd, 16'hBEEF);
    check("mid_rst_rdy", cmd_rdy, 1'b1);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_idx", mv_indx, 5'd0);
    check("mid_rst_idle", resp, 8'hA5);
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    check("post_rst_stray_idx", mv_indx, 5'd0);
    check("post_rst_stray_resp", resp, 8'hA5);

    // Fresh tour after reset still sequences correctly
    pulse_start();
    do_move(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 Parameter NUM_MOVES, default 24, meaning number of L-moves in a 5x5 tour, last index NUM_MOVES-1.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start_tour  in  1  one-cycle pulse from tour solver: solution ready, begin sequencing.
REQ-005 move  in  8  one-hot move for index mv_indx, read from solver memory.
REQ-006 mv_indx  out  5  current move index into solver memory.
REQ-007 cmd_UART  in  16  command received from UART wrapper.
REQ-008 cmd_rdy_UART  in  1  UART command valid.
REQ-009 clr_cmd_rdy  in  1  cmd_proc consumed the current command.
REQ-010 send_resp  in  1  cmd_proc finished executing the current command.
REQ-011 cmd  out  16  command presented to cmd_proc.
REQ-012 cmd_rdy  out  1  cmd valid to cmd_proc.
REQ-013 clr_cmd_rdy_UART  out  1  forwarded consume strobe to UART wrapper.
REQ-014 resp  out  8  response byte returned to remote.

Function
REQ-015 FSM states SHALL be IDLE, VERT, HOLD_VERT, HORZ, HOLD_HORZ.
REQ-016 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
REQ-017 All non-IDLE states: cmd from tour logic, clr_cmd_rdy_UART=0, cmd_rdy_UART ignored.
REQ-018 IDLE & start_tour -> VERT; mv_indx cleared to 0; start_tour ignored in any other state.
REQ-019 On entry to VERT, move SHALL be registered; decoding uses the registered copy only.
REQ-020 Move bits: b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1), b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1), as (dx,dy).
REQ-021 Vertical cmd: opcode 4'h4, heading 8'h00 if dy>0 else 8'h7F, squares |dy|.
REQ-022 Horizontal cmd: opcode 4'h5 (move with fanfare), heading 8'hBF if dx>0 else 8'h3F, squares |dx|.
REQ-023 VERT and HORZ SHALL drive cmd_rdy=1; clr_cmd_rdy moves VERT->HOLD_VERT and HORZ->HOLD_HORZ, cmd_rdy low from the next cycle.
REQ-024 HOLD_VERT & send_resp -> HORZ; HOLD_HORZ & send_resp -> VERT with mv_indx+1, or IDLE if mv_indx==NUM_MOVES-1.
REQ-025 resp=8'h5A in all non-IDLE states, except 8'hA5 in HOLD_HORZ when mv_indx==NUM_MOVES-1.
REQ-026 Registered move zero or not one-hot SHALL abort to IDLE in the next cycle, with no cmd_rdy issued.
REQ-027 send_resp outside HOLD states and clr_cmd_rdy outside VERT/HORZ SHALL be ignored.
REQ-028 mv_indx SHALL never exceed NUM_MOVES-1 and SHALL not wrap.

Reset
REQ-029 rst_n low at a clock edge: state IDLE, mv_indx 0, move register 0, tour cmd_rdy 0; this applies mid-tour too.
REQ-030 Outputs in reset follow IDLE mux rules: resp=8'hA5, cmd/cmd_rdy pass through the UART inputs.

Structure
REQ-031 Shared knights_pkg SHALL hold the heading constants NORTH/SOUTH/EAST/WEST, opcodes MOVE/MOVE_FANFARE, and the FSM state enum.
REQ-032 Combinational sub-module move_decode SHALL map the one-hot move to vertical cmd, horizontal cmd and a valid flag; tour_cmd holds all sequential logic.

Verification
REQ-033 IDLE: cmd_UART=16'h2000 with cmd_rdy_UART=1 -> cmd=16'h2000, cmd_rdy=1, clr_cmd_rdy pulse mirrored on clr_cmd_rdy_UART, resp=8'hA5.
REQ-034 start_tour with move=8'h01 -> cmd=16'h4002, cmd_rdy=1; after clr_cmd_rdy and send_resp -> cmd=16'h5BF1; after send_resp, mv_indx=1; resp=8'h5A throughout.
REQ-035 move=8'h08 -> vertical 16'h47F1, horizontal 16'h53F2.
REQ-036 Full 24-move run -> final HOLD_HORZ resp=8'hA5, returns to IDLE, mv_indx stays 23.
REQ-037 move=8'h00 or 8'h03 at VERT entry -> IDLE next cycle, cmd_rdy never asserted.
REQ-038 rst_n low during HOLD_HORZ of move 5 -> IDLE, mv_indx=0; start_tour mid-tour and stray send_resp are ignored.
